// File: rtl/time_field_editor_if.sv
// Button / status bundle between the push-button front end and the
// mode/field-edit controller. The master drives the button pulses and held
// levels. The slave (the controller) drives the registered status and strobes.
// There is no valid/ready handshake here. The button inputs are single-cycle
// pulses sampled on every rising clk_out edge. The outputs are levels or
// single-cycle strobes that are valid in every cycle after the edge that
// produced them.
interface time_field_editor_if #(
  parameter int NUM_FIELDS = 4
);
  localparam int FW = $clog2(NUM_FIELDS);

  logic                  btn_c;
  logic                  btn_u;
  logic                  btn_d;
  logic                  btn_l;
  logic                  btn_r;
  logic                  up_held;
  logic                  dn_held;
  logic                  run_en;
  logic                  edit_mode;
  logic [FW-1:0]         field_sel;
  logic [NUM_FIELDS-1:0] inc_pulse;
  logic [NUM_FIELDS-1:0] dec_pulse;
  logic                  disp_sel;
  logic [NUM_FIELDS:0]   leds;
  logic                  timeout_evt;
  logic                  state_dbg;

  modport master (
    output btn_c, btn_u, btn_d, btn_l, btn_r, up_held, dn_held,
    input  run_en, edit_mode, field_sel, inc_pulse, dec_pulse, disp_sel,
           leds, timeout_evt, state_dbg
  );

  modport slave (
    input  btn_c, btn_u, btn_d, btn_l, btn_r, up_held, dn_held,
    output run_en, edit_mode, field_sel, inc_pulse, dec_pulse, disp_sel,
           leds, timeout_evt, state_dbg
  );
endinterface

// File: rtl/time_field_editor.sv
// Mode/field-edit controller for the alarm clock. It has two states:
// - RUN: the time bank counts.
// - EDIT: the buttons select a field and issue inc/dec strobes to it.
// An idle timeout in EDIT returns the block to RUN. All outputs are registered.
// Optional macro TFE_AUTO_REPEAT_EN adds hold-to-repeat on the up/down buttons.
// The default build leaves it out.
module time_field_editor #(
  parameter int NUM_FIELDS    = 4,
  parameter int DISP_SPLIT    = 2,
  parameter int TIMEOUT_TICKS = 2000,
  parameter int REPEAT_DELAY  = 100,
  parameter int REPEAT_RATE   = 20
) (
  input logic                 clk_out,
  input logic                 rst,
  time_field_editor_if.slave  bus
);
  localparam int FW          = $clog2(NUM_FIELDS);
  localparam int IW          = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam int IDLE_LAST_I = (TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_LAST_I);
  localparam logic [FW-1:0] FIELD_LAST = FW'(NUM_FIELDS - 1);

  typedef enum logic {ST_RUN, ST_EDIT} state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         field_q, field_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [NUM_FIELDS-1:0] inc_d, dec_d;
  logic [NUM_FIELDS:0]   leds_d;
  logic                  tevt_d;
  logic                  valid;
  logic                  activity;

`ifdef TFE_AUTO_REPEAT_EN
  localparam int RMAX        = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW          = (RMAX > 0) ? $clog2(RMAX + 1) : 1;
  localparam int DELAY_M1    = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
  localparam int RATE_M1     = (REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0;

  typedef enum logic [1:0] {REP_NONE, REP_UP, REP_DN} rep_dir_t;

  rep_dir_t      rep_dir_q, rep_dir_d;
  logic          rep_rate_q, rep_rate_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [RW-1:0] rep_target;
  logic          rep_held;
`endif

  assign valid         = $onehot({bus.btn_c, bus.btn_u, bus.btn_d, bus.btn_l, bus.btn_r});
  assign bus.state_dbg = (state_q == ST_EDIT);

  // State, selected field and idle counter; asynchronous reset to RUN / field 0
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      field_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      idle_q  <= idle_d;
    end
  end

`ifdef TFE_AUTO_REPEAT_EN
  // Auto-repeat tracking: direction, delay/rate phase and hold counter
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      rep_dir_q  <= REP_NONE;
      rep_rate_q <= 1'b0;
      rep_cnt_q  <= '0;
    end else begin
      rep_dir_q  <= rep_dir_d;
      rep_rate_q <= rep_rate_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end
`endif

  // Next-state, field, strobe, repeat and idle-timeout decisions
  always_comb begin
    state_d  = state_q;
    field_d  = field_q;
    idle_d   = idle_q;
    inc_d    = '0;
    dec_d    = '0;
    tevt_d   = 1'b0;
    activity = 1'b0;
`ifdef TFE_AUTO_REPEAT_EN
    rep_dir_d  = rep_dir_q;
    rep_rate_d = rep_rate_q;
    rep_cnt_d  = rep_cnt_q;
    rep_target = rep_rate_q ? RW'(RATE_M1) : RW'(DELAY_M1);
    rep_held   = (rep_dir_q == REP_UP) ? bus.up_held : bus.dn_held;
`endif
    case (state_q)
      ST_RUN: begin
        idle_d = '0;
        if (valid && bus.btn_c) begin
          state_d = ST_EDIT;
          field_d = '0;
        end
      end
      default: begin
        if (valid) begin
          // Every valid button counts as activity and restarts any repeat
          activity = 1'b1;
`ifdef TFE_AUTO_REPEAT_EN
          rep_dir_d  = REP_NONE;
          rep_rate_d = 1'b0;
          rep_cnt_d  = '0;
`endif
          if (bus.btn_c) begin
            state_d = ST_RUN;
          end else if (bus.btn_r) begin
            field_d = (field_q == FIELD_LAST) ? '0 : field_q + 1'b1;
          end else if (bus.btn_l) begin
            field_d = (field_q == '0) ? FIELD_LAST : field_q - 1'b1;
          end else if (bus.btn_u) begin
            inc_d[field_q] = 1'b1;
`ifdef TFE_AUTO_REPEAT_EN
            rep_dir_d = REP_UP;
`endif
          end else begin
            dec_d[field_q] = 1'b1;
`ifdef TFE_AUTO_REPEAT_EN
            rep_dir_d = REP_DN;
`endif
          end
        end
`ifdef TFE_AUTO_REPEAT_EN
        else if (rep_dir_q != REP_NONE) begin
          if (!rep_held || (bus.up_held && bus.dn_held)) begin
            rep_dir_d  = REP_NONE;
            rep_rate_d = 1'b0;
            rep_cnt_d  = '0;
          end else if (rep_cnt_q == rep_target) begin
            // Repeat strobe: counts as activity; later strobes use the rate period
            activity   = 1'b1;
            rep_rate_d = 1'b1;
            rep_cnt_d  = '0;
            if (rep_dir_q == REP_UP) inc_d[field_q] = 1'b1;
            else                     dec_d[field_q] = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
`endif
        // Activity in this cycle beats a timeout terminal count in the same cycle
        if (activity) begin
          idle_d = '0;
        end else if ((TIMEOUT_TICKS != 0) && (idle_q == IDLE_LAST)) begin
          state_d = ST_RUN;
          tevt_d  = 1'b1;
`ifdef TFE_AUTO_REPEAT_EN
          rep_dir_d  = REP_NONE;
          rep_rate_d = 1'b0;
          rep_cnt_d  = '0;
`endif
        end else if (idle_q != '1) begin
          idle_d = idle_q + 1'b1;
        end
        if (state_d == ST_RUN) idle_d = '0;
      end
    endcase
    leds_d[0] = (state_d == ST_RUN);
    for (int k = 0; k < NUM_FIELDS; k++) begin
      leds_d[k+1] = (state_d == ST_EDIT) && (field_d == FW'(k));
    end
  end

  // Registered outputs, computed from the next state so they change one cycle after the button
  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      bus.run_en      <= 1'b1;
      bus.edit_mode   <= 1'b0;
      bus.field_sel   <= '0;
      bus.inc_pulse   <= '0;
      bus.dec_pulse   <= '0;
      bus.disp_sel    <= 1'b0;
      bus.leds        <= {{NUM_FIELDS{1'b0}}, 1'b1};
      bus.timeout_evt <= 1'b0;
    end else begin
      bus.run_en      <= (state_d == ST_RUN);
      bus.edit_mode   <= (state_d == ST_EDIT);
      bus.field_sel   <= field_d;
      bus.inc_pulse   <= inc_d;
      bus.dec_pulse   <= dec_d;
      bus.disp_sel    <= (state_d == ST_EDIT) && (int'(field_d) >= DISP_SPLIT);
      bus.leds        <= leds_d;
      bus.timeout_evt <= tevt_d;
    end
  end
endmodule
